// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard unit.
// One shadow-pipeline entry describes a single in-flight register write.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF     = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } fwd_entry_t;

  // x0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic entry_match(input fwd_entry_t e, input logic [REG_ADDR_W-1:0] addr);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == addr);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand matcher: priority-encodes the youngest forwardable producer for the
// EX copy of the operand and flags a too-young load producer for the ID copy.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_ADDR_W-1:0]  ex_addr,
  input  logic [REG_ADDR_W-1:0]  id_addr,
  input  fwd_entry_t [FWD_DEPTH:0] entries,
  output logic [SEL_W-1:0]       sel,
  output logic                   load_hit
);

  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_hit = 1'b0;
    // Walk oldest to youngest so the youngest qualifying producer is written last.
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (entry_match(entries[k], ex_addr) && (!entries[k].is_load || k >= LOAD_STAGE)) begin
        sel = SEL_W'(k);
      end
    end
    // Load data in stages below LOAD_STAGE-1 cannot reach EX in time for the ID instruction.
    for (int k = 0; k <= LOAD_STAGE - 2; k++) begin
      if (entry_match(entries[k], id_addr) && entries[k].is_load) begin
        load_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall generation for the pipelined core.
// Tracks in-flight writes from EX through writeback in an internal shadow pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic [31:0]                   stall_cnt
);

  fwd_entry_t [FWD_DEPTH:0]      pipe;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
  logic [NUM_SRC-1:0]            load_hit;

  // Entry 0 mirrors EX; a stall or flush turns EX into a bubble with cleared operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe  <= '0;
      ex_rs <= '0;
    end else begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        pipe[k] <= pipe[k-1];
      end
      if (flush || stall) begin
        pipe[0] <= '0;
        ex_rs   <= '0;
      end else begin
        pipe[0] <= fwd_entry_t'{valid: id_valid, rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
        ex_rs   <= id_rs;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_match #(
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SEL_W     (SEL_W)
    ) u_match (
      .ex_addr (ex_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
      .id_addr (id_rs[gi*REG_ADDR_W +: REG_ADDR_W]),
      .entries (pipe),
      .sel     (fwd_sel[gi*SEL_W +: SEL_W]),
      .load_hit(load_hit[gi])
    );
  end

  // Flush wins over a load-use hazard: the killed instruction needs no stall.
  assign stall = id_valid & ~flush & (|load_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: default instance plus a
// LOAD_STAGE=3 / FWD_DEPTH=3 instance sharing the same ID-stage stimulus.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [4:0]  id_rd = '0;
  logic        id_regwrite = 1'b0;
  logic        id_is_load = 1'b0;
  logic        flush = 1'b0;

  logic [3:0]  fwd_sel;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [3:0]  fwd_sel3;
  logic        stall3;
  logic [31:0] stall_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.NUM_SRC(2), .FWD_DEPTH(3), .LOAD_STAGE(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel3), .stall(stall3), .stall_cnt(stall_cnt3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic ld);
    id_valid    = v;
    id_rs       = {rs2, rs1};
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic apply_reset();
    nop();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b1;
    #2;
    if (fwd_sel !== 4'd0) begin $display("FAIL rst_fwd_sel: got %0h want 0", fwd_sel); n_err++; end
    n_cmp++;
    if (stall !== 1'b0) begin $display("FAIL rst_stall: got %0b want 0", stall); n_err++; end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); n_err++; end
    n_cmp++;
    apply_reset();
    tick();
    if (fwd_sel !== 4'd0) begin $display("FAIL post_rst_fwd_sel: got %0h want 0", fwd_sel); n_err++; end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin $display("FAIL post_rst_stall_cnt: got %0d want 0", stall_cnt); n_err++; end
    n_cmp++;
  endtask

  task automatic test_mem_fwd();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // addi x5,x1,imm
    tick();
    issue(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
    #1;
    if (stall !== 1'b0) begin $display("FAIL mem_stall: got %0b want 0", stall); n_err++; end
    n_cmp++;
    tick();
    nop();
    if (fwd_sel !== 4'b0101) begin $display("FAIL mem_fwd_sel: got %0h want 5", fwd_sel); n_err++; end
    n_cmp++;
  endtask

  task automatic test_wb_fwd();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);   // addi x5
    tick();
    nop();
    tick();
    issue(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0);   // sub x7,x5,x0
    tick();
    nop();
    if (fwd_sel !== 4'b0010) begin $display("FAIL wb_fwd_sel: got %0h want 2", fwd_sel); n_err++; end
    n_cmp++;
  endtask

  task automatic test_youngest_wins();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    issue(1'b1, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0);   // add x8,x5,x0
    tick();
    nop();
    if (fwd_sel !== 4'b0001) begin $display("FAIL young_fwd_sel: got %0h want 1", fwd_sel); n_err++; end
    n_cmp++;
  endtask

  task automatic test_x0_nowrite();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);   // addi x0
    tick();
    issue(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);   // add x3,x0,x0
    tick();
    nop();
    if (fwd_sel !== 4'b0000) begin $display("FAIL x0_fwd_sel: got %0h want 0", fwd_sel); n_err++; end
    n_cmp++;
    apply_reset();
    issue(1'b1, 5'd2, 5'd9, 5'd9, 1'b0, 1'b0);   // sw x9,(x2); rd field carries imm bits = 9
    tick();
    issue(1'b1, 5'd9, 5'd9, 5'd4, 1'b1, 1'b0);   // add x4,x9,x9
    tick();
    nop();
    if (fwd_sel !== 4'b0000) begin $display("FAIL sw_fwd_sel: got %0h want 0", fwd_sel); n_err++; end
    n_cmp++;
  endtask

  task automatic test_load_use();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
    tick();
    issue(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
    #1;
    if (stall !== 1'b1) begin $display("FAIL lu_stall1: got %0b want 1", stall); n_err++; end
    n_cmp++;
    tick();
    if (stall !== 1'b0) begin $display("FAIL lu_stall2: got %0b want 0", stall); n_err++; end
    n_cmp++;
    if (stall_cnt !== 32'd1) begin $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); n_err++; end
    n_cmp++;
    tick();
    nop();
    if (fwd_sel !== 4'b0010) begin $display("FAIL lu_fwd_sel: got %0h want 2", fwd_sel); n_err++; end
    n_cmp++;
    if (stall_cnt !== 32'd1) begin $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); n_err++; end
    n_cmp++;
  endtask

  task automatic test_load_stage3();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);   // lw x5
    tick();
    issue(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1, held in ID while stalled
    #1;
    if (stall3 !== 1'b1) begin $display("FAIL ls3_stall1: got %0b want 1", stall3); n_err++; end
    n_cmp++;
    tick();
    if (stall3 !== 1'b1) begin $display("FAIL ls3_stall2: got %0b want 1", stall3); n_err++; end
    n_cmp++;
    tick();
    if (stall3 !== 1'b0) begin $display("FAIL ls3_stall3: got %0b want 0", stall3); n_err++; end
    n_cmp++;
    tick();
    nop();
    if (fwd_sel3 !== 4'b0011) begin $display("FAIL ls3_fwd_sel: got %0h want 3", fwd_sel3); n_err++; end
    n_cmp++;
    if (stall_cnt3 !== 32'd2) begin $display("FAIL ls3_cnt: got %0d want 2", stall_cnt3); n_err++; end
    n_cmp++;
  endtask

  task automatic test_flush();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);   // lw x5
    tick();
    issue(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);   // dependent add, killed
    flush = 1'b1;
    #1;
    if (stall !== 1'b0) begin $display("FAIL fl_stall: got %0b want 0", stall); n_err++; end
    n_cmp++;
    tick();
    nop();
    if (stall_cnt !== 32'd0) begin $display("FAIL fl_cnt: got %0d want 0", stall_cnt); n_err++; end
    n_cmp++;
    if (fwd_sel !== 4'b0000) begin $display("FAIL fl_fwd_sel: got %0h want 0", fwd_sel); n_err++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    issue(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0);   // addi x7
    tick();
    issue(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);   // lw x5
    tick();
    issue(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);   // add x6,x5,x7
    tick();
    if (stall3 !== 1'b1) begin $display("FAIL mid_pre_stall3: got %0b want 1", stall3); n_err++; end
    n_cmp++;
    #2;
    rst = 1'b1;
    #1;
    if (stall3 !== 1'b0) begin $display("FAIL mid_stall3: got %0b want 0", stall3); n_err++; end
    n_cmp++;
    if (stall_cnt3 !== 32'd0) begin $display("FAIL mid_cnt3: got %0d want 0", stall_cnt3); n_err++; end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin $display("FAIL mid_cnt: got %0d want 0", stall_cnt); n_err++; end
    n_cmp++;
    if (fwd_sel !== 4'b0000 || fwd_sel3 !== 4'b0000) begin
      $display("FAIL mid_fwd_sel: got %0h/%0h want 0/0", fwd_sel, fwd_sel3); n_err++;
    end
    n_cmp++;
    tick();
    rst = 1'b0;
    nop();
  endtask

  initial begin
    test_reset();
    test_mem_fwd();
    test_wb_fwd();
    test_youngest_wins();
    test_x0_nowrite();
    test_load_use();
    test_load_stage3();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
